// File: rtl/bullet_selector.sv
// Bullet-type selector and fire controller: per-type ammo tracking, fire cooldown,
// reload, next-type cycling and optional fallback to the unlimited default weapon.
module bullet_selector #(
    parameter int NUM_TYPES     = 5,
    parameter int SEL_W         = 3,
    parameter int AMMO_W        = 4,
    parameter int MAX_AMMO      = 9,
    parameter int COOLDOWN      = 8,
    parameter bit AUTO_FALLBACK = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_TYPES-1:0] sel_n,
    input  logic                 cycle_next,
    input  logic                 shoot,
    input  logic                 reload,
    output logic [SEL_W-1:0]     bullet_type,
    output logic                 fire,
    output logic [SEL_W-1:0]     fire_type,
    output logic [AMMO_W-1:0]    ammo,
    output logic                 empty,
    output logic                 busy
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [AMMO_W-1:0] FULL      = AMMO_W'(MAX_AMMO);
    localparam logic [SEL_W-1:0]  LAST_TYPE = SEL_W'(NUM_TYPES - 1);
    localparam logic [CW-1:0]     COOL_LOAD = CW'(COOLDOWN - 1);

    typedef enum logic {READY, COOL} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cool_cnt, cool_cnt_next;
    logic [AMMO_W-1:0]    counts      [NUM_TYPES];
    logic [AMMO_W-1:0]    counts_next [NUM_TYPES];
    logic                 shoot_q;
    logic                 armed;
    logic                 req;
    logic                 has_ammo;
    logic                 do_fire;
    logic                 sel_hit;
    logic [SEL_W-1:0]     sel_idx;
    logic [SEL_W-1:0]     type_next;
    logic [AMMO_W-1:0]    ammo_next;

    // armed stays low while shoot is held low across reset, so releasing reset
    // with the button down is not mistaken for a fresh falling edge.
    always_comb begin
        req      = shoot_q & ~shoot & armed;
        has_ammo = (bullet_type == '0) || (counts[bullet_type] != '0);
        do_fire  = (state == READY) && req && has_ammo;

        counts_next = counts;
        counts_next[0] = FULL;
        for (int i = 1; i < NUM_TYPES; i++) begin
            if (reload)
                counts_next[i] = FULL;
            else if (do_fire && (bullet_type == SEL_W'(i)))
                counts_next[i] = counts[i] - AMMO_W'(1);
        end

        sel_hit = 1'b0;
        sel_idx = '0;
        for (int i = NUM_TYPES - 1; i >= 0; i--) begin
            if (!sel_n[i]) begin
                sel_hit = 1'b1;
                sel_idx = SEL_W'(i);
            end
        end

        if (sel_hit)
            type_next = sel_idx;
        else if (cycle_next)
            type_next = (bullet_type == LAST_TYPE) ? '0 : bullet_type + SEL_W'(1);
        else if (AUTO_FALLBACK && (bullet_type != '0) && (counts[bullet_type] == '0))
            type_next = '0;
        else
            type_next = bullet_type;

        ammo_next = (type_next == '0) ? FULL : counts_next[type_next];

        state_next    = state;
        cool_cnt_next = cool_cnt;
        if (state == READY) begin
            if (do_fire) begin
                state_next    = COOL;
                cool_cnt_next = COOL_LOAD;
            end
        end else begin
            if (cool_cnt == '0)
                state_next = READY;
            else
                cool_cnt_next = cool_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= READY;
            cool_cnt    <= '0;
            shoot_q     <= 1'b1;
            armed       <= shoot;
            for (int i = 0; i < NUM_TYPES; i++)
                counts[i] <= FULL;
            bullet_type <= '0;
            fire        <= 1'b0;
            fire_type   <= '0;
            ammo        <= FULL;
            empty       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            cool_cnt    <= cool_cnt_next;
            shoot_q     <= shoot;
            armed       <= armed | shoot;
            counts      <= counts_next;
            bullet_type <= type_next;
            fire        <= do_fire;
            fire_type   <= do_fire ? bullet_type : '0;
            ammo        <= ammo_next;
            empty       <= (type_next != '0) && (ammo_next == '0);
            busy        <= (state_next == COOL);
        end
    end

endmodule

// File: tb/tb_bullet_selector.sv
// Directed bench for bullet_selector: default instance plus a no-fallback instance
// sharing the same stimulus.
module tb_bullet_selector;

    logic       clk;
    logic       reset;
    logic [4:0] sel_n;
    logic       cycle_next;
    logic       shoot;
    logic       reload;

    logic [2:0] bullet_type, fire_type, nf_bullet_type, nf_fire_type;
    logic [3:0] ammo, nf_ammo;
    logic       fire, empty, busy, nf_fire, nf_empty, nf_busy;

    int checks   = 0;
    int failures = 0;

    bullet_selector dut (
        .clk(clk), .reset(reset), .sel_n(sel_n), .cycle_next(cycle_next),
        .shoot(shoot), .reload(reload), .bullet_type(bullet_type), .fire(fire),
        .fire_type(fire_type), .ammo(ammo), .empty(empty), .busy(busy)
    );

    bullet_selector #(.AUTO_FALLBACK(1'b0)) dut_nf (
        .clk(clk), .reset(reset), .sel_n(sel_n), .cycle_next(cycle_next),
        .shoot(shoot), .reload(reload), .bullet_type(nf_bullet_type), .fire(nf_fire),
        .fire_type(nf_fire_type), .ammo(nf_ammo), .empty(nf_empty), .busy(nf_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; shoot = 1'b1; sel_n = 5'b11111; cycle_next = 1'b0; reload = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        checks++; if (bullet_type !== 3'd0) begin failures++; $display("[TB] FAIL reset_type got=%0d want=0", bullet_type); end
        checks++; if (fire !== 1'b0) begin failures++; $display("[TB] FAIL reset_fire got=%b want=0", fire); end
        checks++; if (fire_type !== 3'd0) begin failures++; $display("[TB] FAIL reset_fire_type got=%0d want=0", fire_type); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (empty !== 1'b0) begin failures++; $display("[TB] FAIL reset_empty got=%b want=0", empty); end
        checks++; if (ammo !== 4'd9) begin failures++; $display("[TB] FAIL reset_ammo got=%0d want=9", ammo); end
    endtask

    task automatic test_default_fire;
        int nbusy;
        int extra;
        shoot = 1'b0;
        step(1);
        checks++; if (fire !== 1'b1) begin failures++; $display("[TB] FAIL dflt_fire got=%b want=1", fire); end
        checks++; if (fire_type !== 3'd0) begin failures++; $display("[TB] FAIL dflt_fire_type got=%0d want=0", fire_type); end
        checks++; if (ammo !== 4'd9) begin failures++; $display("[TB] FAIL dflt_ammo got=%0d want=9", ammo); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL dflt_busy got=%b want=1", busy); end
        shoot = 1'b1;
        nbusy = 1;
        extra = 0;
        step(1);
        for (int i = 0; i < 20 && busy; i++) begin
            if (fire) extra++;
            nbusy++;
            step(1);
        end
        checks++; if (nbusy != 8) begin failures++; $display("[TB] FAIL dflt_busy_len got=%0d want=8", nbusy); end
        checks++; if (extra != 0) begin failures++; $display("[TB] FAIL dflt_fire_width got=%0d extra want=0", extra); end
    endtask

    task automatic test_depletion;
        sel_n = 5'b11101;
        step(1);
        sel_n = 5'b11111;
        checks++; if (bullet_type !== 3'd1) begin failures++; $display("[TB] FAIL depl_sel got=%0d want=1", bullet_type); end
        checks++; if (ammo !== 4'd9) begin failures++; $display("[TB] FAIL depl_start_ammo got=%0d want=9", ammo); end
        for (int k = 1; k <= 9; k++) begin
            shoot = 1'b0;
            step(1);
            checks++; if (fire !== 1'b1 || fire_type !== 3'd1) begin failures++; $display("[TB] FAIL depl_fire_%0d got=%b/%0d want=1/1", k, fire, fire_type); end
            checks++; if (ammo !== 4'(9 - k)) begin failures++; $display("[TB] FAIL depl_ammo_%0d got=%0d want=%0d", k, ammo, 9 - k); end
            checks++; if (nf_ammo !== 4'(9 - k)) begin failures++; $display("[TB] FAIL depl_nf_ammo_%0d got=%0d want=%0d", k, nf_ammo, 9 - k); end
            shoot = 1'b1;
            step(1);
            if (k == 9) begin
                checks++; if (bullet_type !== 3'd0) begin failures++; $display("[TB] FAIL depl_fallback got=%0d want=0", bullet_type); end
                checks++; if (ammo !== 4'd9 || empty !== 1'b0) begin failures++; $display("[TB] FAIL depl_fallback_ammo got=%0d/%b want=9/0", ammo, empty); end
                checks++; if (nf_bullet_type !== 3'd1) begin failures++; $display("[TB] FAIL depl_nf_hold got=%0d want=1", nf_bullet_type); end
                checks++; if (nf_empty !== 1'b1) begin failures++; $display("[TB] FAIL depl_nf_empty got=%b want=1", nf_empty); end
            end
            step(8);
        end
        shoot = 1'b0;
        step(1);
        checks++; if (nf_fire !== 1'b0) begin failures++; $display("[TB] FAIL depl_nf_dry_fire got=%b want=0", nf_fire); end
        checks++; if (nf_empty !== 1'b1) begin failures++; $display("[TB] FAIL depl_nf_dry_empty got=%b want=1", nf_empty); end
        checks++; if (fire !== 1'b1 || fire_type !== 3'd0) begin failures++; $display("[TB] FAIL depl_type0_fire got=%b/%0d want=1/0", fire, fire_type); end
        shoot = 1'b1;
        step(10);
    endtask

    task automatic test_cooldown_drop;
        int nfires;
        shoot = 1'b0;
        step(1);
        checks++; if (fire !== 1'b1) begin failures++; $display("[TB] FAIL cool_first got=%b want=1", fire); end
        shoot = 1'b1;
        step(3);
        shoot = 1'b0;
        step(1);
        checks++; if (fire !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL cool_drop got=%b/%b want=0/1", fire, busy); end
        shoot = 1'b1;
        nfires = 0;
        repeat (15) begin
            step(1);
            if (fire) nfires++;
        end
        checks++; if (nfires != 0) begin failures++; $display("[TB] FAIL cool_no_replay got=%0d want=0", nfires); end
    endtask

    task automatic test_priority_wrap;
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd1; exp_seq[1] = 3'd2; exp_seq[2] = 3'd3; exp_seq[3] = 3'd3;
        sel_n = 5'b10011;
        step(1);
        checks++; if (bullet_type !== 3'd2 || ammo !== 4'd9) begin failures++; $display("[TB] FAIL prio_lowest got=%0d/%0d want=2/9", bullet_type, ammo); end
        sel_n = 5'b01111;
        step(1);
        checks++; if (bullet_type !== 3'd4) begin failures++; $display("[TB] FAIL prio_type4 got=%0d want=4", bullet_type); end
        sel_n = 5'b11111;
        cycle_next = 1'b1;
        step(1);
        checks++; if (bullet_type !== 3'd0) begin failures++; $display("[TB] FAIL wrap got=%0d want=0", bullet_type); end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) cycle_next = 1'b0;
            step(1);
            checks++; if (bullet_type !== exp_seq[i]) begin failures++; $display("[TB] FAIL cycle_%0d got=%0d want=%0d", i, bullet_type, exp_seq[i]); end
            if (i == 0) begin
                checks++; if (empty !== 1'b1 || ammo !== 4'd0) begin failures++; $display("[TB] FAIL cycle_empty got=%b/%0d want=1/0", empty, ammo); end
            end
        end
    endtask

    task automatic test_simultaneous;
        reload = 1'b1;
        sel_n = 5'b11101;
        step(1);
        reload = 1'b0;
        sel_n = 5'b11111;
        checks++; if (bullet_type !== 3'd1 || ammo !== 4'd9) begin failures++; $display("[TB] FAIL sim_reload got=%0d/%0d want=1/9", bullet_type, ammo); end
        shoot = 1'b0;
        sel_n = 5'b10111;
        step(1);
        checks++; if (fire !== 1'b1 || fire_type !== 3'd1) begin failures++; $display("[TB] FAIL sim_old_type got=%b/%0d want=1/1", fire, fire_type); end
        checks++; if (bullet_type !== 3'd3 || ammo !== 4'd9) begin failures++; $display("[TB] FAIL sim_new_sel got=%0d/%0d want=3/9", bullet_type, ammo); end
        shoot = 1'b1;
        sel_n = 5'b11111;
        step(10);
        sel_n = 5'b11101;
        step(1);
        sel_n = 5'b11111;
        checks++; if (bullet_type !== 3'd1 || ammo !== 4'd8) begin failures++; $display("[TB] FAIL sim_decrement got=%0d/%0d want=1/8", bullet_type, ammo); end
        shoot = 1'b0;
        reload = 1'b1;
        step(1);
        checks++; if (fire !== 1'b1 || fire_type !== 3'd1 || ammo !== 4'd9) begin failures++; $display("[TB] FAIL sim_fire_reload got=%b/%0d/%0d want=1/1/9", fire, fire_type, ammo); end
        shoot = 1'b1;
        reload = 1'b0;
        step(10);
    endtask

    task automatic test_reset_mid_cool;
        int nfires;
        shoot = 1'b0;
        step(1);
        checks++; if (fire !== 1'b1 || busy !== 1'b1 || ammo !== 4'd8) begin failures++; $display("[TB] FAIL rst_pre_fire got=%b/%b/%0d want=1/1/8", fire, busy, ammo); end
        shoot = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        checks++; if (busy !== 1'b0 || bullet_type !== 3'd0 || ammo !== 4'd9) begin failures++; $display("[TB] FAIL rst_abort got=%b/%0d/%0d want=0/0/9", busy, bullet_type, ammo); end
        shoot = 1'b0;
        step(2);
        reset = 1'b0;
        nfires = 0;
        repeat (5) begin
            step(1);
            if (fire) nfires++;
        end
        checks++; if (nfires != 0) begin failures++; $display("[TB] FAIL rst_held_shoot got=%0d fires want=0", nfires); end
        shoot = 1'b1;
        sel_n = 5'b11101;
        step(1);
        sel_n = 5'b11111;
        checks++; if (bullet_type !== 3'd1 || ammo !== 4'd9 || empty !== 1'b0) begin failures++; $display("[TB] FAIL rst_refill got=%0d/%0d/%b want=1/9/0", bullet_type, ammo, empty); end
    endtask

    initial begin
        reset = 1'b1; shoot = 1'b1; sel_n = 5'b11111; cycle_next = 1'b0; reload = 1'b0;
        test_reset;
        test_default_fire;
        test_depletion;
        test_cooldown_drop;
        test_priority_wrap;
        test_simultaneous;
        test_reset_mid_cool;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
